// File: rtl/prot_bus_master.sv
// Autonomous Wishbone initiator for the protection peripheral: heartbeat-gated
// watchdog kicks, periodic FAULT_LATCH polling and clear-then-verify sequences.
module prot_bus_master #(
    parameter int unsigned KICK_PERIOD = 1_000_000,
    parameter int unsigned POLL_PERIOD = 1_000,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [7:0]  BASE_ADDR   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic        wb_stb,
    input  logic        wb_ack,
    input  logic        enable,
    input  logic        heartbeat,
    input  logic        clear_req,
    output logic [3:0]  fault_code,
    output logic        fault_valid,
    output logic        clear_done,
    output logic        clear_fail,
    output logic        bus_err,
    output logic        busy
);
    localparam int KW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [7:0] KICK_ADDR  = BASE_ADDR + 8'h10;
    localparam logic [7:0] LATCH_ADDR = BASE_ADDR + 8'h14;
    localparam logic [7:0] CLEAR_ADDR = BASE_ADDR + 8'h08;

    typedef enum logic [2:0] {IDLE, KICK, POLL, CLEAR, VERIFY} state_t;

    state_t         state, nxt_state;
    logic [KW-1:0]  kick_cnt;
    logic [PW-1:0]  poll_cnt;
    logic [TW-1:0]  to_cnt;
    logic           kick_pend, poll_pend, clear_pend, hb_seen;
    logic           launch_clr, launch_kick, launch_poll;
    logic [7:0]     nxt_addr;
    logic           nxt_we;
    logic [31:0]    nxt_dat;
    logic           kick_tc, poll_tc, clr_accept;
    logic           unused_dat;

    assign unused_dat  = ^wb_dat_i[31:4];
    assign kick_tc     = (kick_cnt == KW'(KICK_PERIOD - 1));
    assign poll_tc     = (poll_cnt == PW'(POLL_PERIOD - 1));
    assign clr_accept  = enable && clear_req && !clear_pend;
    assign fault_valid = |fault_code;
    assign busy        = (state != IDLE);

    // Arbitration: only evaluated while IDLE, so every access is preceded by an idle cycle.
    always_comb begin
        launch_clr  = 1'b0;
        launch_kick = 1'b0;
        launch_poll = 1'b0;
        nxt_state   = IDLE;
        nxt_addr    = LATCH_ADDR;
        nxt_we      = 1'b0;
        nxt_dat     = '0;
        if (state == IDLE && enable) begin
            if (clear_pend) begin
                launch_clr = 1'b1;
                nxt_state  = CLEAR;
                nxt_addr   = CLEAR_ADDR;
                nxt_we     = 1'b1;
                nxt_dat    = {28'd0, fault_code};
            end else if (kick_pend && hb_seen) begin
                launch_kick = 1'b1;
                nxt_state   = KICK;
                nxt_addr    = KICK_ADDR;
                nxt_we      = 1'b1;
            end else if (poll_pend) begin
                launch_poll = 1'b1;
                nxt_state   = POLL;
            end
        end
    end

    // Timers and pending flags; a set in the same cycle as a launch wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kick_cnt   <= '0;
            poll_cnt   <= '0;
            kick_pend  <= 1'b0;
            poll_pend  <= 1'b0;
            clear_pend <= 1'b0;
            hb_seen    <= 1'b0;
        end else if (!enable) begin
            kick_cnt   <= '0;
            poll_cnt   <= '0;
            kick_pend  <= 1'b0;
            poll_pend  <= 1'b0;
            clear_pend <= 1'b0;
            hb_seen    <= 1'b0;
        end else begin
            kick_cnt   <= kick_tc ? '0 : kick_cnt + 1'b1;
            poll_cnt   <= poll_tc ? '0 : poll_cnt + 1'b1;
            // A kick due without a heartbeat is dropped so the slave watchdog can expire.
            kick_pend  <= kick_tc | (kick_pend & ~launch_kick & hb_seen);
            poll_pend  <= poll_tc | (poll_pend & ~launch_poll);
            clear_pend <= clr_accept | (clear_pend & ~launch_clr);
            hb_seen    <= heartbeat | (hb_seen & ~launch_kick);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wb_addr    <= '0;
            wb_dat_o   <= '0;
            wb_we      <= 1'b0;
            wb_sel     <= '0;
            wb_stb     <= 1'b0;
            to_cnt     <= '0;
            fault_code <= '0;
            clear_done <= 1'b0;
            clear_fail <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (clr_accept) clear_fail <= 1'b0;
            if (!enable)    bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt_state != IDLE) begin
                        state    <= nxt_state;
                        wb_addr  <= nxt_addr;
                        wb_we    <= nxt_we;
                        wb_dat_o <= nxt_dat;
                        wb_stb   <= 1'b1;
                        wb_sel   <= 4'hF;
                    end
                end
                default: begin
                    if (!wb_stb) begin
                        // Idle gap between CLEAR and its VERIFY read.
                        if (enable) begin
                            wb_addr  <= LATCH_ADDR;
                            wb_we    <= 1'b0;
                            wb_dat_o <= '0;
                            wb_stb   <= 1'b1;
                            wb_sel   <= 4'hF;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wb_ack) begin
                        wb_stb <= 1'b0;
                        wb_sel <= '0;
                        to_cnt <= '0;
                        state  <= IDLE;
                        case (state)
                            POLL: fault_code <= wb_dat_i[3:0];
                            CLEAR: if (enable) state <= VERIFY;
                            VERIFY: begin
                                fault_code <= wb_dat_i[3:0];
                                clear_done <= 1'b1;
                                clear_fail <= |wb_dat_i[3:0];
                            end
                            default: ;
                        endcase
                    end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        // Abort without retry; a timed-out CLEAR never reaches VERIFY.
                        wb_stb  <= 1'b0;
                        wb_sel  <= '0;
                        to_cnt  <= '0;
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prot_bus_master.sv
// Bench for prot_bus_master: protection slave model with watchdog and fault latch,
// a bus monitor, and per-scenario tasks checked against expectations from the block's rules.
module tb_prot_bus_master;
    localparam int KP = 20, PP = 8, AT = 16, WD_LIM = 45;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  wb_addr;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_we, wb_stb;
    logic        wb_ack = 1'b0;
    logic [3:0]  wb_sel;
    logic        enable = 1'b0, heartbeat = 1'b0, clear_req = 1'b0;
    logic [3:0]  fault_code;
    logic        fault_valid, clear_done, clear_fail, bus_err, busy;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    prot_bus_master #(.KICK_PERIOD(KP), .POLL_PERIOD(PP), .ACK_TIMEOUT(AT), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_ack(wb_ack), .enable(enable),
        .heartbeat(heartbeat), .clear_req(clear_req), .fault_code(fault_code),
        .fault_valid(fault_valid), .clear_done(clear_done), .clear_fail(clear_fail),
        .bus_err(bus_err), .busy(busy));

    // Slave: registered ack, write-1-to-clear latch, level OCP source, kick-fed watchdog.
    logic [3:0] latch = 4'h0, inj = 4'h0;
    logic       ocp = 1'b0, noack = 1'b0, wd_armed = 1'b0, flush = 1'b0;
    int         wd_cnt = 0;
    wire        wr_ack = wb_stb && wb_ack && wb_we;
    assign wb_dat_i = (wb_addr == 8'h14) ? {28'd0, latch} : 32'd0;

    always @(posedge clk) begin
        wb_ack <= wb_stb && !wb_ack && !noack;
        wd_cnt <= (!wd_armed || (wr_ack && wb_addr == 8'h10)) ? 0 : wd_cnt + 1;
        if (flush) latch <= 4'h0;
        else latch <= (latch & ~((wr_ack && wb_addr == 8'h08) ? wb_dat_o[3:0] : 4'h0))
                      | inj | {3'b000, ocp} | {(wd_armed && wd_cnt >= WD_LIM), 3'b000};
    end

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdat, rdat;
        int          len, gap, start;
        bit          acked, stable, sel_ok;
    } txn_t;
    txn_t q[$];
    txn_t cur;
    int   idle_run = 0, done_cnt = 0, ncyc = 0;
    bit   prev_stb = 1'b0;

    initial forever begin
        @(negedge clk);
        ncyc++;
        if (clear_done) done_cnt++;
        if (wb_stb) begin
            if (!prev_stb) begin
                cur.addr = wb_addr; cur.we = wb_we; cur.wdat = wb_dat_o; cur.rdat = 32'd0;
                cur.len = 0; cur.gap = idle_run; cur.start = ncyc;
                cur.acked = 1'b0; cur.stable = 1'b1; cur.sel_ok = 1'b1;
            end
            cur.len++;
            if (wb_addr !== cur.addr || wb_we !== cur.we || wb_dat_o !== cur.wdat) cur.stable = 1'b0;
            if (wb_sel !== 4'hF) cur.sel_ok = 1'b0;
            if (wb_ack) begin cur.acked = 1'b1; cur.rdat = wb_dat_i; end
            idle_run = 0;
        end else begin
            if (prev_stb) q.push_back(cur);
            idle_run++;
        end
        prev_stb = wb_stb;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic inject(input logic [3:0] v);
        inj = v; tick(); inj = 4'h0;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
    endtask

    task automatic go_idle();
        int n;
        enable = 1'b0;
        for (n = 0; n < 40 && busy; n++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n); end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        tick(3);
        checks++;
        if ({wb_stb, wb_sel, wb_we, wb_addr, wb_dat_o} !== 46'd0) begin
            errors++; $display("FAIL reset_bus: stb=%b sel=%h we=%b addr=%h dat=%h, required all 0", wb_stb, wb_sel, wb_we, wb_addr, wb_dat_o);
        end
        checks++;
        if ({fault_code, fault_valid, clear_done, clear_fail, bus_err, busy} !== 9'd0) begin
            errors++; $display("FAIL reset_status: code=%h valid=%b done=%b fail=%b err=%b busy=%b, required all 0", fault_code, fault_valid, clear_done, clear_fail, bus_err, busy);
        end
        @(negedge clk); rst_n = 1'b1; tick();
    endtask

    // Heartbeat every 10 cycles: one kick write per KICK_PERIOD, polls interleaved.
    task automatic test_kick();
        int nk, last, badgap;
        pulse_flush(); q.delete(); enable = 1'b1;
        for (int e = 1; e <= 210; e++) begin
            heartbeat = (e % 10 == 5);
            @(posedge clk); #1;
            heartbeat = 1'b0;
        end
        go_idle();
        nk = 0; last = -1; badgap = 0;
        foreach (q[i]) begin
            if (i > 0 && q[i].gap < 1) badgap++;
            if (q[i].addr == 8'h10 && q[i].we) begin
                nk++;
                checks++;
                if (q[i].len != 2 || !q[i].sel_ok || !q[i].stable || !q[i].acked || q[i].wdat != 32'd0) begin
                    errors++; $display("FAIL kick_shape: len=%0d sel_ok=%b stable=%b acked=%b dat=%h, required 2/1/1/1/0", q[i].len, q[i].sel_ok, q[i].stable, q[i].acked, q[i].wdat);
                end
                if (last >= 0) begin
                    checks++;
                    if (q[i].start - last != KP) begin errors++; $display("FAIL kick_interval: got %0d cycles, required %0d", q[i].start - last, KP); end
                end
                last = q[i].start;
            end
        end
        checks++;
        if (nk != 210 / KP) begin errors++; $display("FAIL kick_count: got %0d, required %0d", nk, 210 / KP); end
        checks++;
        if (badgap != 0) begin errors++; $display("FAIL kick_gaps: %0d accesses with no idle cycle before them, required 0", badgap); end
        checks++;
        if (fault_code !== 4'h0) begin errors++; $display("FAIL kick_code: fault_code=%h, required 0", fault_code); end
    endtask

    // Single heartbeat: exactly one kick, then the watchdog fires and polling reports bit3.
    task automatic test_hb_stop();
        int nk, t_lat, t_fc;
        pulse_flush(); q.delete(); wd_armed = 1'b1; enable = 1'b1;
        t_lat = -1; t_fc = -1;
        for (int e = 1; e <= 150; e++) begin
            heartbeat = (e == 3);
            @(posedge clk); #1;
            heartbeat = 1'b0;
            if (t_lat < 0 && latch[3]) t_lat = e;
            if (t_fc < 0 && fault_code[3]) t_fc = e;
        end
        nk = 0;
        foreach (q[i]) if (q[i].addr == 8'h10 && q[i].we) nk++;
        checks++;
        if (nk != 1) begin errors++; $display("FAIL hb_stop_kicks: got %0d kicks, required 1", nk); end
        checks++;
        if (fault_code[3] !== 1'b1 || fault_valid !== 1'b1) begin errors++; $display("FAIL hb_stop_code: fault_code=%h valid=%b, required bit3 set and valid", fault_code, fault_valid); end
        checks++;
        if (t_lat < 0 || t_fc < 0 || t_fc - t_lat > PP + 3) begin
            errors++; $display("FAIL hb_stop_latency: latch at %0d, fault_code at %0d, required within %0d", t_lat, t_fc, PP + 3);
        end
        wd_armed = 1'b0;
        go_idle();
        pulse_flush();
    endtask

    // Random latch contents: poll reports them, clear writes them back, verify reads zero.
    task automatic test_poll_clear();
        logic [3:0] v;
        int d0, ci;
        pulse_flush(); ocp = 1'b0; enable = 1'b1; tick(PP + 6);
        for (int it = 0; it < 4; it++) begin
            v = (it == 0) ? 4'h5 : 4'($urandom_range(1, 15));
            inject(v); tick(PP + 6);
            checks++;
            if (fault_code !== v || fault_valid !== 1'b1) begin errors++; $display("FAIL poll_code: fault_code=%h valid=%b, required %h/1", fault_code, fault_valid, v); end
            q.delete(); d0 = done_cnt;
            pulse_clear(); tick(20);
            ci = -1;
            foreach (q[i]) if (ci < 0 && q[i].addr == 8'h08 && q[i].we) ci = i;
            checks++;
            if (ci < 0 || ci + 1 >= q.size()) begin
                errors++; $display("FAIL clear_seq: clear write index %0d of %0d accesses, required write then verify", ci, q.size());
            end else begin
                checks++;
                if (q[ci].wdat !== {28'd0, v} || q[ci].len != 2) begin errors++; $display("FAIL clear_data: dat=%h len=%0d, required %h/2", q[ci].wdat, q[ci].len, v); end
                checks++;
                if (q[ci+1].addr != 8'h14 || q[ci+1].we || q[ci+1].rdat != 32'd0 || q[ci+1].gap != 1) begin
                    errors++; $display("FAIL verify_read: addr=%h we=%b rdat=%h gap=%0d, required 14/0/0/1", q[ci+1].addr, q[ci+1].we, q[ci+1].rdat, q[ci+1].gap);
                end
            end
            checks++;
            if (done_cnt - d0 != 1) begin errors++; $display("FAIL clear_done: %0d pulse cycles, required 1", done_cnt - d0); end
            checks++;
            if (clear_fail !== 1'b0 || fault_code !== 4'h0) begin errors++; $display("FAIL clear_result: fail=%b code=%h, required 0/0", clear_fail, fault_code); end
        end
        go_idle();
    endtask

    // OCP held high re-latches bit0 after the clear, so the verify read must flag failure.
    task automatic test_clear_fail();
        logic [3:0] v;
        int d0;
        pulse_flush(); ocp = 1'b1; enable = 1'b1;
        v = (4'($urandom_range(0, 7)) << 1) | 4'h1;
        inject(v); tick(PP + 6);
        checks++;
        if (fault_code !== v) begin errors++; $display("FAIL fail_poll: fault_code=%h, required %h", fault_code, v); end
        d0 = done_cnt;
        pulse_clear(); tick(20);
        checks++;
        if (clear_fail !== 1'b1 || fault_code !== 4'h1 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL fail_verify: fail=%b code=%h done=%0d, required 1/1/1", clear_fail, fault_code, done_cnt - d0);
        end
        ocp = 1'b0; tick(PP + 6);
        pulse_clear();
        checks++;
        if (clear_fail !== 1'b0) begin errors++; $display("FAIL fail_cleared_by_req: clear_fail=%b, required 0", clear_fail); end
        tick(20);
        checks++;
        if (clear_fail !== 1'b0 || fault_code !== 4'h0) begin errors++; $display("FAIL fail_reclear: fail=%b code=%h, required 0/0", clear_fail, fault_code); end
        go_idle();
    endtask

    // Slave never acks: stb held ACK_TIMEOUT cycles, bus_err set, cleared by enable low.
    task automatic test_timeout();
        int n;
        logic be, bz, sb;
        pulse_flush(); noack = 1'b1; q.delete(); enable = 1'b1;
        for (n = 0; n < 60 && !bus_err; n++) tick();
        be = bus_err; bz = busy; sb = wb_stb;
        enable = 1'b0;
        tick(2);
        checks++;
        if (be !== 1'b1 || bz !== 1'b0 || sb !== 1'b0) begin errors++; $display("FAIL timeout_state: bus_err=%b busy=%b stb=%b, required 1/0/0", be, bz, sb); end
        checks++;
        if (q.size() < 1 || q[0].len != AT || q[0].acked) begin
            errors++; $display("FAIL timeout_len: %0d accesses, first stb length %0d, required %0d unacked", q.size(), (q.size() > 0) ? q[0].len : -1, AT);
        end
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: bus_err=%b with enable low, required 0", bus_err); end
        noack = 1'b0;
        go_idle();
    endtask

    // clear_req, kick and poll due together: CLEAR, VERIFY, KICK, POLL; then async reset mid-POLL.
    task automatic test_back_to_back();
        logic [7:0] exp_a [4] = '{8'h08, 8'h14, 8'h10, 8'h14};
        logic       exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int n;
        logic sb;
        pulse_flush(); ocp = 1'b0; enable = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            heartbeat = (e == 30);
            clear_req = (e == 40);
            @(posedge clk); #1;
            heartbeat = 1'b0; clear_req = 1'b0;
        end
        q.delete();
        for (n = 0; n < 40 && !(q.size() == 3 && wb_stb); n++) tick();
        @(negedge clk); #1;
        sb = wb_stb;
        checks++;
        if (n >= 40 || sb !== 1'b1) begin errors++; $display("FAIL b2b_fourth_start: waited %0d cycles, stb=%b, required 4th access in flight", n, sb); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_stb !== 1'b0 || busy !== 1'b0 || wb_sel !== 4'h0) begin
            errors++; $display("FAIL async_reset: stb=%b busy=%b sel=%h, required 0/0/0", wb_stb, busy, wb_sel);
        end
        tick(2);
        checks++;
        if (q.size() != 4) begin
            errors++; $display("FAIL b2b_count: %0d accesses, required 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q[i].addr != exp_a[i] || q[i].we != exp_w[i] || (i > 0 && q[i].gap != 1) || (i < 3 && q[i].len != 2)) begin
                    errors++; $display("FAIL b2b_order[%0d]: addr=%h we=%b gap=%0d len=%0d, required %h/%b/1/2", i, q[i].addr, q[i].we, q[i].gap, q[i].len, exp_a[i], exp_w[i]);
                end
            end
        end
        enable = 1'b0;
        @(negedge clk); rst_n = 1'b1; tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_kick();
        test_hb_stop();
        test_poll_clear();
        test_clear_fail();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
